// File: rtl/multi_timer.sv
// multi_timer: parametrised multi-channel programmable tick generator.
// Each channel is a down-counter that emits a registered one-cycle tick when
// it expires. Channels run in periodic or one-shot mode. Each channel is
// started and stopped individually and reprogrammed through one write port.
// Optional feature: define MULTI_TIMER_PRESCALE_EN to add a shared prescaler
// (parameter PRESCALE). Channels then count only on prescaler strobe cycles.
module multi_timer #(
  parameter int               WIDTH          = 32,
  parameter int               CHANNELS       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(25000000)
`ifdef MULTI_TIMER_PRESCALE_EN
  ,
  parameter int               PRESCALE       = 50
`endif
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                                   cfg_period,
  input  logic                                               cfg_oneshot,
  input  logic [CHANNELS-1:0]                                start,
  input  logic [CHANNELS-1:0]                                stop,
  output logic [CHANNELS-1:0]                                tick,
  output logic [CHANNELS-1:0]                                running,
  output logic [CHANNELS-1:0]                                expired,
  output logic                                               tick_any
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Per-channel state
  logic [WIDTH-1:0]    r_period [CHANNELS];
  logic [WIDTH-1:0]    r_count  [CHANNELS];
  logic [CHANNELS-1:0] r_oneshot;
  logic [CHANNELS-1:0] r_running;
  logic [CHANNELS-1:0] r_expired;
  logic [CHANNELS-1:0] r_tick;
  logic                r_tick_any;

  // Next-state values
  logic [WIDTH-1:0]    w_period_n     [CHANNELS];
  logic [WIDTH-1:0]    w_count_n      [CHANNELS];
  logic [WIDTH-1:0]    w_eff_period   [CHANNELS];
  logic [CHANNELS-1:0] w_oneshot_n;
  logic [CHANNELS-1:0] w_running_n;
  logic [CHANNELS-1:0] w_expired_n;
  logic [CHANNELS-1:0] w_tick_n;
  logic [CHANNELS-1:0] w_hit;
  logic [WIDTH-1:0]    w_wr_period;
  logic                w_step;

  // A programmed period of 0 is stored as 1, so a reload is never below zero.
  assign w_wr_period = (cfg_period == '0) ? WIDTH'(1) : cfg_period;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] r_prescale;

  assign w_step = (r_prescale == PS_W'(PRESCALE - 1));

  // Free-running shared prescaler, 0..PRESCALE-1, strobing at the top value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
    end else if (w_step) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PS_W'(1);
    end
  end
`else
  assign w_step = 1'b1;
`endif

  // Per-channel next state: config write, then stop > start > counting step
  always_comb begin
    w_hit       = '0;
    w_oneshot_n = r_oneshot;
    w_running_n = r_running;
    w_expired_n = r_expired;
    w_tick_n    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_period_n[i]   = r_period[i];
      w_count_n[i]    = r_count[i];
      w_eff_period[i] = r_period[i];
      // Only indices below CHANNELS can match, so out-of-range writes are dropped.
      w_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      if (w_hit[i]) begin
        w_period_n[i]   = w_wr_period;
        w_oneshot_n[i]  = cfg_oneshot;
        w_eff_period[i] = w_wr_period;
      end else begin
        w_period_n[i]   = r_period[i];
        w_oneshot_n[i]  = r_oneshot[i];
        w_eff_period[i] = r_period[i];
      end

      if (stop[i]) begin
        // Count holds and any coincident expiry is swallowed.
        w_running_n[i] = 1'b0;
      end else if (start[i]) begin
        // A same-cycle write is already reflected in w_eff_period.
        w_count_n[i]   = w_eff_period[i] - WIDTH'(1);
        w_running_n[i] = 1'b1;
        w_expired_n[i] = 1'b0;
      end else if (r_running[i] && w_step) begin
        if (r_count[i] != '0) begin
          w_count_n[i] = r_count[i] - WIDTH'(1);
        end else begin
          w_tick_n[i] = 1'b1;
          if (r_oneshot[i]) begin
            w_running_n[i] = 1'b0;
            w_expired_n[i] = 1'b1;
          end else begin
            w_count_n[i] = r_period[i] - WIDTH'(1);
          end
        end
      end else begin
        w_count_n[i] = r_count[i];
      end
    end
  end

  // Channel state and registered tick outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_period[i] <= DEFAULT_PERIOD;
        r_count[i]  <= '0;
      end
      r_oneshot  <= '0;
      r_running  <= '0;
      r_expired  <= '0;
      r_tick     <= '0;
      r_tick_any <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_period[i] <= w_period_n[i];
        r_count[i]  <= w_count_n[i];
      end
      r_oneshot  <= w_oneshot_n;
      r_running  <= w_running_n;
      r_expired  <= w_expired_n;
      r_tick     <= w_tick_n;
      r_tick_any <= |w_tick_n;
    end
  end

  assign tick     = r_tick;
  assign running  = r_running;
  assign expired  = r_expired;
  assign tick_any = r_tick_any;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (5 channels, 16-bit, default period 6).
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_oneshot;
  logic [4:0]  start;
  logic [4:0]  stop;
  logic [4:0]  tick;
  logic [4:0]  running;
  logic [4:0]  expired;
  logic        tick_any;

  int n_vec = 0;
  int n_bad = 0;

  multi_timer #(
    .WIDTH(16),
    .CHANNELS(5),
    .DEFAULT_PERIOD(16'd6)
`ifdef MULTI_TIMER_PRESCALE_EN
    ,
    .PRESCALE(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .tick(tick), .running(running),
    .expired(expired), .tick_any(tick_any)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [15:0] p, input logic os);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] m);
    start = m;
    step();
    start = 5'd0;
  endtask

  task automatic pulse_stop(input logic [4:0] m);
    stop = m;
    step();
    stop = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_vec++; if (tick !== 5'd0) begin n_bad++; $display("FAIL reset_tick got %b want 00000", tick); end
    n_vec++; if (running !== 5'd0) begin n_bad++; $display("FAIL reset_running got %b want 00000", running); end
    n_vec++; if (expired !== 5'd0) begin n_bad++; $display("FAIL reset_expired got %b want 00000", expired); end
    n_vec++; if (tick_any !== 1'b0) begin n_bad++; $display("FAIL reset_tick_any got %b want 0", tick_any); end
    rst = 1'b0;
    step();
    n_vec++; if (running !== 5'd0) begin n_bad++; $display("FAIL reset_idle got %b want 00000", running); end
  endtask

`ifdef MULTI_TIMER_PRESCALE_EN
  task automatic test_prescale();
    int found = 0;
    write_cfg(3'd0, 16'd3, 1'b0);
    pulse_start(5'b00001);
    for (int j = 0; j < 30 && found == 0; j++) begin
      step();
      if (tick[0] === 1'b1) found = 1;
    end
    n_vec++; if (found == 0) begin n_bad++; $display("FAIL prescale_first_tick got none want one within 30 cycles"); end
    for (int j = 1; j <= 24; j++) begin
      step();
      n_vec++;
      if (tick[0] !== (j % 12 == 0)) begin
        n_bad++; $display("FAIL prescale_tick j=%0d got %b want %b", j, tick[0], (j % 12 == 0));
      end
    end
    pulse_stop(5'b00001);
  endtask
`else
  task automatic test_default_period();
    pulse_start(5'b11111);
    n_vec++; if (running !== 5'b11111) begin n_bad++; $display("FAIL default_running got %b want 11111", running); end
    for (int j = 1; j <= 7; j++) begin
      step();
      n_vec++;
      if (tick !== ((j == 6) ? 5'b11111 : 5'b00000)) begin
        n_bad++; $display("FAIL default_tick j=%0d got %b", j, tick);
      end
      n_vec++;
      if (tick_any !== (j == 6)) begin
        n_bad++; $display("FAIL default_tick_any j=%0d got %b want %b", j, tick_any, (j == 6));
      end
    end
    pulse_stop(5'b11111);
    n_vec++; if (running !== 5'd0) begin n_bad++; $display("FAIL default_stop got %b want 00000", running); end
  endtask

  task automatic test_periodic();
    write_cfg(3'd0, 16'd5, 1'b0);
    pulse_start(5'b00001);
    for (int j = 1; j <= 26; j++) begin
      step();
      n_vec++;
      if (tick[0] !== (j % 5 == 0) || tick_any !== (j % 5 == 0) || running[0] !== 1'b1) begin
        n_bad++; $display("FAIL periodic j=%0d tick=%b any=%b run=%b want tick=%b", j, tick[0], tick_any, running[0], (j % 5 == 0));
      end
    end
    pulse_stop(5'b00001);
  endtask

  task automatic test_oneshot();
    write_cfg(3'd1, 16'd3, 1'b1);
    pulse_start(5'b00010);
    for (int j = 1; j <= 20; j++) begin
      step();
      n_vec++;
      if (tick[1] !== (j == 3) || running[1] !== (j < 3) || expired[1] !== (j >= 3)) begin
        n_bad++; $display("FAIL oneshot j=%0d tick=%b run=%b exp=%b want %b %b %b",
                          j, tick[1], running[1], expired[1], (j == 3), (j < 3), (j >= 3));
      end
    end
    pulse_start(5'b00010);
    n_vec++;
    if (expired[1] !== 1'b0 || running[1] !== 1'b1) begin
      n_bad++; $display("FAIL oneshot_restart run=%b exp=%b want 1 0", running[1], expired[1]);
    end
    pulse_stop(5'b00010);
  endtask

  task automatic test_zero_period();
    write_cfg(3'd2, 16'd0, 1'b0);
    pulse_start(5'b00100);
    for (int j = 1; j <= 5; j++) begin
      step();
      n_vec++; if (tick[2] !== 1'b1) begin n_bad++; $display("FAIL zero_period j=%0d got %b want 1", j, tick[2]); end
    end
    pulse_stop(5'b00100);
    n_vec++;
    if (tick[2] !== 1'b0 || running[2] !== 1'b0) begin
      n_bad++; $display("FAIL zero_period_stop tick=%b run=%b want 0 0", tick[2], running[2]);
    end
  endtask

  task automatic test_start_stop();
    start = 5'b01000; stop = 5'b01000;
    step();
    start = 5'd0; stop = 5'd0;
    n_vec++; if (running[3] !== 1'b0) begin n_bad++; $display("FAIL start_stop_run got %b want 0", running[3]); end
    for (int j = 1; j <= 8; j++) begin
      step();
      n_vec++; if (tick[3] !== 1'b0) begin n_bad++; $display("FAIL start_stop_tick j=%0d got %b want 0", j, tick[3]); end
    end
  endtask

  task automatic test_restart();
    write_cfg(3'd4, 16'd4, 1'b0);
    pulse_start(5'b10000);
    for (int j = 1; j <= 9; j++) begin
      if (j == 3) start = 5'b10000;
      step();
      start = 5'd0;
      n_vec++;
      if (tick[4] !== (j == 7)) begin n_bad++; $display("FAIL restart j=%0d got %b want %b", j, tick[4], (j == 7)); end
    end
    pulse_stop(5'b10000);
  endtask

  task automatic test_reprogram();
    logic e;
    write_cfg(3'd2, 16'd4, 1'b0);
    pulse_start(5'b00100);
    for (int j = 1; j <= 25; j++) begin
      if (j == 6) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_period = 16'd8; cfg_oneshot = 1'b0; end
      step();
      cfg_we = 1'b0;
      e = (j == 4) || (j == 8) || (j == 16) || (j == 24);
      n_vec++;
      if (tick[2] !== e) begin n_bad++; $display("FAIL reprogram j=%0d got %b want %b", j, tick[2], e); end
    end
    pulse_stop(5'b00100);
  endtask

  task automatic test_bad_ch();
    write_cfg(3'd5, 16'd2, 1'b0);
    pulse_start(5'b00011);
    for (int j = 1; j <= 6; j++) begin
      step();
      n_vec++;
      if (tick[0] !== (j == 5) || tick[1] !== (j == 3)) begin
        n_bad++; $display("FAIL bad_ch j=%0d tick0=%b tick1=%b want %b %b", j, tick[0], tick[1], (j == 5), (j == 3));
      end
    end
    n_vec++; if (expired[1] !== 1'b1) begin n_bad++; $display("FAIL bad_ch_expired got %b want 1", expired[1]); end
  endtask

  task automatic test_reset_mid();
    pulse_start(5'b00001);
    step();
    rst = 1'b1;
    #1;
    n_vec++;
    if (tick !== 5'd0 || running !== 5'd0 || expired !== 5'd0 || tick_any !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid tick=%b run=%b exp=%b any=%b want all 0", tick, running, expired, tick_any);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      n_vec++;
      if (tick !== 5'd0 || running !== 5'd0) begin
        n_bad++; $display("FAIL reset_release j=%0d tick=%b run=%b want 0 0", j, tick, running);
      end
    end
    pulse_start(5'b00001);
    for (int j = 1; j <= 6; j++) begin
      step();
      n_vec++;
      if (tick[0] !== (j == 6)) begin n_bad++; $display("FAIL reset_default_period j=%0d got %b want %b", j, tick[0], (j == 6)); end
    end
    pulse_stop(5'b00001);
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_period = 16'd0; cfg_oneshot = 1'b0;
    start = 5'd0; stop = 5'd0;
    test_reset();
`ifdef MULTI_TIMER_PRESCALE_EN
    test_prescale();
`else
    test_default_period();
    test_periodic();
    test_oneshot();
    test_zero_period();
    test_start_stop();
    test_restart();
    test_reprogram();
    test_bad_ch();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
